// File: rtl/vga_scan_gen_if.sv
// Scan-generator bundle: scroll controls in, raster position/sync/scroll offset out.
// The generator side uses the master modport; the pixel pipeline consumes via slave.
interface vga_scan_gen_if;
   logic       scroll_en;
   logic [3:0] scroll_step;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic       frame_tick;
   logic [9:0] x_offset;

   modport master (
      input  scroll_en,
      input  scroll_step,
      output hpos,
      output vpos,
      output hsync,
      output vsync,
      output display_on,
      output frame_tick,
      output x_offset
   );

   modport slave (
      output scroll_en,
      output scroll_step,
      input  hpos,
      input  vpos,
      input  hsync,
      input  vsync,
      input  display_on,
      input  frame_tick,
      input  x_offset
   );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster counter with zero-latency sync/blank decode and a per-frame scroll offset.
// Define VGA_SCAN_SCROLL_EN to build the x_offset register; otherwise x_offset is tied to 0.
module vga_scan_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic          clk,
   input  logic          reset,
   vga_scan_gen_if.master scan
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_wrap;
   logic       v_wrap;
   logic       frame_end;

   assign h_wrap    = (h_cnt == H_LAST);
   assign v_wrap    = (v_cnt == V_LAST);
   assign frame_end = h_wrap && v_wrap;

   // Raster counters: vpos only moves on the clock where hpos wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // All decodes come straight off the counter registers so they stay mutually aligned.
   assign scan.hpos       = h_cnt;
   assign scan.vpos       = v_cnt;
   assign scan.hsync      = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
   assign scan.vsync      = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
   assign scan.display_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign scan.frame_tick = frame_end;

`ifdef VGA_SCAN_SCROLL_EN
   logic [9:0] x_off_q;

   // One conditional subtract suffices because both operands are already below H_DISPLAY+16.
   function automatic logic [9:0] wrap_add(input logic [9:0] base, input logic [3:0] step);
      logic [10:0] sum;
      sum = {1'b0, base} + {7'd0, step};
      if (sum >= 11'(H_DISPLAY))
         sum = sum - 11'(H_DISPLAY);
      return sum[9:0];
   endfunction

   // Loading on the last pixel makes the new offset appear together with the (0,0) wrap.
   always_ff @(posedge clk) begin
      if (reset)
         x_off_q <= '0;
      else if (frame_end && scan.scroll_en)
         x_off_q <= wrap_add(x_off_q, scan.scroll_step);
   end

   assign scan.x_offset = x_off_q;
`else
   logic unused_scroll;
   assign unused_scroll = ^{scan.scroll_en, scan.scroll_step};
   assign scan.x_offset = '0;
`endif
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: reduced raster geometry, per-cycle reference model plus literal anchors.
// Honours VGA_SCAN_SCROLL_EN the same way the design does.
module tb_vga_scan_gen;
   localparam int HD = 40, HF = 4, HS = 6, HB = 4;
   localparam int VD = 6,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HD + HF + HS + HB;   // 54
   localparam int VT = VD + VF + VS + VB;   // 11
   localparam int FRAME = HT * VT;          // 594
`ifdef VGA_SCAN_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   vga_scan_gen_if scan();

   vga_scan_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .scan (scan.master)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int t       = 0;   // model: position within frame, in pixels since (0,0)
   int exp_x   = 0;   // model: expected scroll offset

   task automatic check_lit(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_cycle();
      int h, v;
      logic e_hs, e_vs, e_de, e_ft;
      h    = t % HT;
      v    = t / HT;
      e_hs = !(h >= HD + HF && h < HD + HF + HS);
      e_vs = !(v >= VD + VF && v < VD + VF + VS);
      e_de = (h < HD) && (v < VD);
      e_ft = (t == FRAME - 1);
      n_tests++;
      if (scan.hpos !== 10'(h) || scan.vpos !== 10'(v) || scan.hsync !== e_hs ||
          scan.vsync !== e_vs || scan.display_on !== e_de || scan.frame_tick !== e_ft ||
          scan.x_offset !== 10'(exp_x)) begin
         n_fail++;
         $display("FAIL scan @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b ft=%b x=%0d, expected h=%0d v=%0d hs=%b vs=%b de=%b ft=%b x=%0d",
                  $time, scan.hpos, scan.vpos, scan.hsync, scan.vsync, scan.display_on,
                  scan.frame_tick, scan.x_offset, h, v, e_hs, e_vs, e_de, e_ft, exp_x);
      end
   endtask

   // Advance the model across one rising edge using the inputs held since the last falling edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         t     = 0;
         exp_x = 0;
      end else begin
         if (SCROLL && t == FRAME - 1 && scan.scroll_en)
            exp_x = (exp_x + int'(scan.scroll_step)) % HD;
         t = (t + 1) % FRAME;
      end
      @(negedge clk);
      check_cycle();
   endtask

   task automatic run_frame(input logic en, input logic [3:0] step);
      scan.scroll_en   = en;
      scan.scroll_step = step;
      for (int i = 0; i < FRAME; i++) tick();
   endtask

   int hs_low, vs_low, ft_cnt, first_ft, ft_h, ft_v, v_before, v_at, h_at;

   initial begin
      scan.scroll_en   = 1'b0;
      scan.scroll_step = 4'd0;
      reset = 1'b1;
      tick();
      tick();
      check_lit("reset_hpos",  int'(scan.hpos), 0);
      check_lit("reset_vpos",  int'(scan.vpos), 0);
      check_lit("reset_hsync", int'(scan.hsync), 1);
      check_lit("reset_vsync", int'(scan.vsync), 1);
      check_lit("reset_de",    int'(scan.display_on), 1);
      check_lit("reset_ft",    int'(scan.frame_tick), 0);
      check_lit("reset_x",     int'(scan.x_offset), 0);

      // First frame after reset: line timing, vsync width, frame_tick placement.
      reset = 1'b0;
      hs_low = 0; vs_low = 0; ft_cnt = 0; first_ft = -1; ft_h = -1; ft_v = -1;
      v_before = -1; v_at = -1; h_at = -1;
      for (int k = 1; k <= FRAME; k++) begin
         tick();
         if (k <= HT && !scan.hsync) hs_low++;
         if (!scan.vsync) vs_low++;
         if (k == HT - 1) v_before = int'(scan.vpos);
         if (k == HT) begin v_at = int'(scan.vpos); h_at = int'(scan.hpos); end
         if (scan.frame_tick) begin
            ft_cnt++;
            if (first_ft < 0) begin
               first_ft = k; ft_h = int'(scan.hpos); ft_v = int'(scan.vpos);
            end
         end
      end
      check_lit("line_hsync_low", hs_low, 6);
      check_lit("vpos_before_wrap", v_before, 0);
      check_lit("vpos_after_wrap", v_at, 1);
      check_lit("hpos_after_wrap", h_at, 0);
      check_lit("frame_vsync_low", vs_low, 108);
      check_lit("frame_tick_count", ft_cnt, 1);
      check_lit("first_tick_latency", first_ft, 593);
      check_lit("tick_hpos", ft_h, 53);
      check_lit("tick_vpos", ft_v, 10);

      // Scroll sequence with hand-computed offsets (mod 40).
      check_lit("scroll_f0", int'(scan.x_offset), 0);
      run_frame(1'b1, 4'd5);
      check_lit("scroll_f1", int'(scan.x_offset), SCROLL ? 5 : 0);
      run_frame(1'b1, 4'd5);
      check_lit("scroll_f2", int'(scan.x_offset), SCROLL ? 10 : 0);
      for (int f = 0; f < 5; f++) run_frame(1'b1, 4'd5);
      check_lit("preload_35", int'(scan.x_offset), SCROLL ? 35 : 0);
      run_frame(1'b1, 4'd7);
      check_lit("wrap_35p7", int'(scan.x_offset), SCROLL ? 2 : 0);
      run_frame(1'b1, 4'd15);
      run_frame(1'b1, 4'd15);
      run_frame(1'b1, 4'd1);
      check_lit("preload_33", int'(scan.x_offset), SCROLL ? 33 : 0);
      run_frame(1'b1, 4'd7);
      check_lit("wrap_33p7", int'(scan.x_offset), SCROLL ? 0 : 0);
      run_frame(1'b1, 4'd3);
      run_frame(1'b1, 4'd0);
      check_lit("step_zero", int'(scan.x_offset), SCROLL ? 3 : 0);
      run_frame(1'b0, 4'd9);
      check_lit("scroll_disabled", int'(scan.x_offset), SCROLL ? 3 : 0);

      // Reset landing exactly on the frame_tick cycle must block the scroll update.
      scan.scroll_en   = 1'b1;
      scan.scroll_step = 4'd4;
      for (int i = 0; i < FRAME - 1; i++) tick();
      check_lit("pre_reset_tick", int'(scan.frame_tick), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_lit("tick_reset_hpos", int'(scan.hpos), 0);
      check_lit("tick_reset_vpos", int'(scan.vpos), 0);
      check_lit("tick_reset_x",    int'(scan.x_offset), 0);

      // Mid-frame reset.
      run_frame(1'b1, 4'd9);
      for (int i = 0; i < 200; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_lit("mid_reset_hpos", int'(scan.hpos), 0);
      check_lit("mid_reset_vpos", int'(scan.vpos), 0);
      check_lit("mid_reset_x",    int'(scan.x_offset), 0);

      // Randomized controls, with the occasional reset pulse.
      for (int i = 0; i < 40 * FRAME; i++) begin
         scan.scroll_en   = 1'($urandom_range(0, 1));
         scan.scroll_step = 4'($urandom_range(0, 15));
         reset            = ($urandom_range(0, 2999) == 0);
         tick();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48: horizontal porch and sync widths, in clocks.
REQ-003 Parameter V_DISPLAY, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33: vertical sizes, in lines.
REQ-004 clk  input  1  pixel clock (25.175 MHz nominal); all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 scroll_en  input  1  enables the per-frame x_offset advance.
REQ-007 scroll_step  input  4  x_offset increment per frame, 0..15.
REQ-008 hpos  output  10  current horizontal count; drives the downstream pix_x.
REQ-009 vpos  output  10  current vertical count; drives the downstream pix_y.
REQ-010 hsync  output  1  horizontal sync, active low.
REQ-011 vsync  output  1  vertical sync, active low.
REQ-012 display_on  output  1  high while (hpos, vpos) is inside the visible area.
REQ-013 frame_tick  output  1  one-clock pulse on the last pixel of each frame.
REQ-014 x_offset  output  10  animation scroll offset; drives the downstream x_offset.

Function
REQ-015 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-016 hpos SHALL increment every clock; at H_TOTAL-1 it wraps to 0 on the next clock.
REQ-017 vpos SHALL increment only on the clock where hpos wraps; at V_TOTAL-1 it wraps to 0 on that same clock.
REQ-018 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751); otherwise 1.
REQ-019 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= vpos <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491); otherwise 1.
REQ-020 display_on SHALL equal (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
REQ-021 hsync, vsync, display_on and frame_tick SHALL be combinational decodes of the current hpos/vpos registers, with zero latency and no skew between them.
REQ-022 frame_tick SHALL be 1 iff hpos == H_TOTAL-1 and vpos == V_TOTAL-1.
REQ-023 On a clock where frame_tick=1 and scroll_en=1, x_offset SHALL load (x_offset + scroll_step) mod H_DISPLAY.
REQ-024 The x_offset sum is formed 11 bits wide; if sum >= H_DISPLAY, H_DISPLAY is subtracted once. No other wrap value is permitted.
REQ-025 x_offset SHALL hold on every other clock, including frame_tick cycles with scroll_en=0.
REQ-026 The new x_offset value SHALL become visible on the same clock that (hpos, vpos) wraps to (0, 0), so it is constant across the whole visible frame.
REQ-027 scroll_step=0 with scroll_en=1 SHALL leave x_offset unchanged.

Reset
REQ-028 While reset=1 at a rising edge: hpos=0, vpos=0, x_offset=0. Decoded outputs follow from these values: hsync=1, vsync=1, display_on=1, frame_tick=0.
REQ-029 Reset asserted mid-frame SHALL take effect at the next edge and override scanning and scroll updates, including on a frame_tick cycle.
REQ-030 After reset deasserts, the first frame_tick SHALL occur exactly H_TOTAL*V_TOTAL-1 (419999) clocks later.

Configuration
REQ-031 Macro VGA_SCAN_SCROLL_EN defined: the x_offset logic is built as in REQ-023..REQ-027.
REQ-032 VGA_SCAN_SCROLL_EN undefined: x_offset SHALL be constant 0, no x_offset register is built, and scroll_en and scroll_step are ignored. All other behaviour is unchanged.

Verification
REQ-033 Reset, then run 800 clocks -> hsync=0 exactly for hpos 656..751 (96 clocks); vpos advances 0->1 on the clock hpos wraps 799->0.
REQ-034 Run one full frame (420000 clocks) -> vsync=0 for exactly 2 lines (vpos 490, 491, 1600 clocks total); frame_tick pulses once, at (799, 524).
REQ-035 With scroll_en=1, scroll_step=5: x_offset reads 0, 5, 10 at frames 0, 1, 2, and changes only at the (0, 0) wrap.
REQ-036 Preload via frames to x_offset=635, then run one frame with scroll_step=7 -> x_offset=2 (wrap); with x_offset=633 and step 7 -> x_offset=0.
REQ-037 Assert reset for 1 clock at hpos=799, vpos=524 with scroll_en=1 -> hpos=0, vpos=0, x_offset=0 and no scroll increment applied.
REQ-038 Build without VGA_SCAN_SCROLL_EN, run 3 frames with scroll_en=1, scroll_step=15 -> x_offset=0 throughout; sync timing identical to REQ-033/REQ-034.
